fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage for the MIPS pipeline and the upstream end of the decode interface. It generates the program counter, issues one-at-a-time requests to instruction memory, and buffers returned words in a 2-entry queue. It presents each word to decode as `insn`/`pc`/`valid_insn`, honouring decode back-pressure and branch/jump redirects.

## Interface
- `RESET_PC`, 32'h8002_0000, first fetch address after reset
- `clk`  in  1  sole clock, all state on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  32  fetch byte address, word aligned
- `imem_ready`  in  1  memory accepts request this cycle (`imem_req && imem_ready` = accept)
- `imem_rvalid`  in  1  response word valid, at least 1 cycle after accept
- `imem_rdata`  in  32  response instruction word
- `stall`  in  1  decode cannot take an instruction this cycle
- `redirect`  in  1  branch/jump taken; restart fetch
- `redirect_pc`  in  32  target address; bits [1:0] forced to 0
- `insn`  out  32  instruction to decode
- `pc`  out  32  address of `insn`
- `valid_insn`  out  1  `insn`/`pc` valid

## Operation
- `fetch_pc` is the next address to request. It advances by 4 on each accept and wraps from 32'hFFFF_FFFC to 0.
- At most one request is outstanding.
- Queue: 2 entries of {word, address}, count 0..2.
  - `valid_insn` = count != 0; `insn`/`pc` = head entry.
  - `insn` and `pc` are driven to 0 when `valid_insn` = 0.
  - Pop on `valid_insn && !stall`. A write and a pop in the same cycle keep count unchanged.
- FSM states:
  - S_REQ: `imem_req`=1, `imem_addr`=`fetch_pc`. On accept -> S_WAIT.
  - S_WAIT: `imem_req`=0. On `imem_rvalid`: push {rdata, request address} unless `drop`. Next state is S_REQ if post-push count < 2, else S_FULL.
  - S_FULL: `imem_req`=0. When count < 2 -> S_REQ.
  - Issuing only with count ≤ 1 and one outstanding request guarantees the queue never overflows. A push into a full queue is an assertion failure.
- Redirect has the highest priority and takes effect at the next edge:
  - Queue flushed (count=0, `valid_insn`=0 next cycle). Any pop in the same cycle is ignored.
  - `fetch_pc` <= `redirect_pc & ~3`.
  - In S_REQ without accept: stay in S_REQ. `imem_addr` changes to the target; the memory samples the address only on accept.
  - In S_REQ with accept that same cycle: the old-address request is in flight -> S_WAIT with `drop`=1.
  - In S_WAIT without `imem_rvalid`: set `drop`=1 and stay in S_WAIT. The response is discarded on arrival, then -> S_REQ.
  - In S_WAIT with `imem_rvalid` the same cycle: the word is discarded -> S_REQ.
  - In S_FULL: -> S_REQ.
  - `drop` clears when the discarded response arrives.
- Redirect during reset is ignored.

## Timing
- Reset values (async, immediate):
  - state = S_REQ, `fetch_pc` = `RESET_PC`, count = 0, `drop` = 0.
  - `imem_req` = 0 while `rst_n` = 0; `imem_addr` = `RESET_PC`.
  - `valid_insn` = 0, `insn` = 0, `pc` = 0.
- First `imem_req` is seen in the first cycle after `rst_n` rises.
- Accept at cycle T, `imem_rvalid` at T+k (k ≥ 1): word is on `valid_insn` at T+k+1. Next request is asserted at T+k+1.
- Peak throughput with k=1 and no stall: one instruction per 2 cycles.
- Redirect asserted at cycle R: a request to the target is asserted at R+1 if no response is pending, otherwise the cycle after the discarded response. The first target instruction is valid no earlier than R+3 with k=1.
- `insn`/`pc` are held stable while `valid_insn && stall`.
- Reset asserted mid-operation: all state cleared at once. A response arriving after reset release with no request outstanding is ignored.

## Test plan
- Reset, `imem_ready`=1, k=1, words = address: request at 8002_0000 first; decode sees pc 8002_0000, 8002_0004, 8002_0008 with `insn` equal to the address, one every 2 cycles.
- `stall`=1 held 10 cycles: exactly 2 entries fill and `imem_req` drops (S_FULL). `insn`/`pc` stay at 8002_0000. After stall release, order is 8002_0000, 8002_0004, 8002_0008, with no loss or duplicates.
- `redirect`=1 to 8002_0100 while a response is pending (k=5): the pending word is never shown. Next request is to 8002_0100; `valid_insn` is 0 until the 8002_0100 word arrives.
- `redirect` to 8002_0203 coincident with `imem_rvalid`: the word is dropped; the next request is to 8002_0200.
- `RESET_PC`=32'hFFFF_FFF8: fetch order FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert `rst_n`=0 for 1 cycle during S_WAIT, with a stale `imem_rvalid` after release: all outputs go to 0 immediately. The stale word is not queued and fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
//   Bundle of the fetch stage's memory and decode-side signals.
//   master : the fetch unit (drives the memory request and the decode outputs)
//   slave  : the environment (instruction memory + decode stage)
//   Memory side : imem_req/imem_addr out, imem_ready/imem_rvalid/imem_rdata in
//   Decode side : stall/redirect/redirect_pc in, insn/pc/valid_insn out
// ---------------------------------------------------------------------------
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] insn;
  logic [31:0] pc;
  logic        valid_insn;

  modport master (
    output imem_req, imem_addr, insn, pc, valid_insn,
    input  imem_ready, imem_rvalid, imem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, insn, pc, valid_insn,
    output imem_ready, imem_rvalid, imem_rdata, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage: generates the PC, issues one request at a time to
//   instruction memory and buffers returned words in a 2-entry queue that
//   feeds decode. Handles decode back-pressure and branch/jump redirects.
//   Ports:
//     clk    - sole clock, all state on posedge
//     rst_n  - asynchronous active-low reset
//     bus    - fetch_unit_if.master (memory request/response, decode outputs)
//   Parameter:
//     RESET_PC - first fetch address after reset
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8002_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] fetch_pc_reg, fetch_pc_next;
  logic [31:0] req_addr_reg;       // address of the request in flight
  logic [1:0]  count_reg, count_next;
  logic        head_reg, head_next;
  logic        drop_reg, drop_next; // in-flight response must be discarded

  logic [31:0] q_word_reg [2];
  logic [31:0] q_addr_reg [2];

  logic accept;
  logic resp;
  logic push;
  logic pop;
  logic wr_idx;

  assign accept = bus.imem_req && bus.imem_ready;
  assign resp   = (state_reg == S_WAIT) && bus.imem_rvalid;
  // A response coinciding with a redirect belongs to the old path.
  assign push   = resp && !drop_reg && !bus.redirect;
  // A redirect flushes the queue, so any simultaneous pop is meaningless.
  assign pop    = (count_reg != 2'd0) && !bus.stall && !bus.redirect;
  // Tail slot sits count entries past the head (modulo 2).
  assign wr_idx = head_reg ^ count_reg[0];

  // -------------------------------------------------------------------------
  // Datapath next-state
  // -------------------------------------------------------------------------
  always_comb begin
    count_next    = count_reg + {1'b0, push} - {1'b0, pop};
    head_next     = pop ? ~head_reg : head_reg;
    fetch_pc_next = accept ? fetch_pc_reg + 32'd4 : fetch_pc_reg;
    drop_next     = drop_reg;
    if (resp) begin
      drop_next = 1'b0;
    end
    if (bus.redirect) begin
      count_next    = 2'd0;
      head_next     = 1'b0;
      fetch_pc_next = bus.redirect_pc & ~32'd3;
      // A request to the old path is (or is about to be) in flight.
      if (accept || ((state_reg == S_WAIT) && !bus.imem_rvalid)) begin
        drop_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_reg <= RESET_PC;
      req_addr_reg <= RESET_PC;
      count_reg    <= 2'd0;
      head_reg     <= 1'b0;
      drop_reg     <= 1'b0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      count_reg    <= count_next;
      head_reg     <= head_next;
      drop_reg     <= drop_next;
      if (accept) begin
        req_addr_reg <= fetch_pc_reg;
      end
    end
  end

  // Queue storage: one register pair per slot.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      localparam logic IDX = 1'(gi);
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_word_reg[gi] <= '0;
          q_addr_reg[gi] <= '0;
        end else if (push && (wr_idx == IDX)) begin
          q_word_reg[gi] <= bus.imem_rdata;
          q_addr_reg[gi] <= req_addr_reg;
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_REQ;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_REQ: begin
        if (accept) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (resp) begin
          if (bus.redirect || drop_reg) begin
            state_next = S_REQ;
          end else if (count_next == 2'd2) begin
            state_next = S_FULL;
          end else begin
            state_next = S_REQ;
          end
        end
      end
      S_FULL: begin
        if (bus.redirect || (count_reg != 2'd2)) begin
          state_next = S_REQ;
        end
      end
      default: state_next = S_REQ;
    endcase
  end

  // FSM: outputs. The request is gated by rst_n so nothing is issued while
  // reset is held even though the state register already reads S_REQ.
  always_comb begin
    bus.imem_req  = rst_n && (state_reg == S_REQ);
    bus.imem_addr = fetch_pc_reg;
  end

  // Decode-side outputs, zeroed when the queue is empty.
  always_comb begin
    bus.valid_insn = (count_reg != 2'd0);
    bus.insn       = '0;
    bus.pc         = '0;
    if (count_reg != 2'd0) begin
      bus.insn = q_word_reg[head_reg];
      bus.pc   = q_addr_reg[head_reg];
    end
  end

  // Request issue is limited so that the queue can never overflow.
  a_no_overflow : assert property (
    @(posedge clk) disable iff (!rst_n) !(push && (count_reg == 2'd2))
  );

endmodule
